// File: rtl/regs_file_if.sv
// Bus between decode/write-back and the architectural register file.
// The master drives read addresses, write-back and scoreboard issue; the slave returns data and busy.
interface regs_file_if #(
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1
);
    logic [READ_PORTS-1:0][4:0]   raddr;
    logic [READ_PORTS-1:0]        rden;
    logic [READ_PORTS-1:0][31:0]  rddata;
    logic [READ_PORTS-1:0]        busy;
    logic                         stall;
    logic [WRITE_PORTS-1:0]       we;
    logic [WRITE_PORTS-1:0][4:0]  waddr;
    logic [WRITE_PORTS-1:0][31:0] wrdata;
    logic [WRITE_PORTS-1:0]       wlong;
    logic                         sb_set;
    logic [4:0]                   sb_addr;

    modport master (
        output raddr, rden, we, waddr, wrdata, wlong, sb_set, sb_addr,
        input  rddata, busy, stall
    );

    modport slave (
        input  raddr, rden, we, waddr, wrdata, wlong, sb_set, sb_addr,
        output rddata, busy, stall
    );
endinterface

// File: rtl/regs_file.sv
// Architectural register file with write-first read bypass and a per-register
// pending scoreboard that stalls decode until long-latency write-backs land.
module regs_file #(
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1,
    parameter int REG_NUM     = 32
) (
    input logic         clk,
    input logic         rst_n,
    regs_file_if.slave  rf
);
    logic [REG_NUM-1:0][31:0] regs;
    logic [REG_NUM-1:0]       pending;

    logic [READ_PORTS-1:0][31:0] rd_data;
    logic [READ_PORTS-1:0]       rd_busy;

    // Later loop iterations override earlier ones, so the highest write port wins,
    // and the scoreboard set is applied after the clears so set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs    <= '0;
            pending <= '0;
        end else begin
            for (int j = 0; j < WRITE_PORTS; j++) begin
                if (rf.we[j] && rf.waddr[j] != 5'd0 && int'(rf.waddr[j]) < REG_NUM) begin
                    regs[rf.waddr[j]] <= rf.wrdata[j];
                    if (rf.wlong[j])
                        pending[rf.waddr[j]] <= 1'b0;
                end
            end
            if (rf.sb_set && rf.sb_addr != 5'd0 && int'(rf.sb_addr) < REG_NUM)
                pending[rf.sb_addr] <= 1'b1;
        end
    end

    // A clearing write-back in the same cycle is forwarded, so it also hides busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < READ_PORTS; i++) begin
            if (rf.raddr[i] != 5'd0 && int'(rf.raddr[i]) < REG_NUM) begin
                rd_data[i] = regs[rf.raddr[i]];
                rd_busy[i] = pending[rf.raddr[i]];
                for (int j = 0; j < WRITE_PORTS; j++) begin
                    if (rf.we[j] && rf.waddr[j] == rf.raddr[i]) begin
                        rd_data[i] = rf.wrdata[j];
                        if (rf.wlong[j])
                            rd_busy[i] = 1'b0;
                    end
                end
            end
        end
    end

    assign rf.rddata = rd_data;
    assign rf.busy   = rd_busy;
    assign rf.stall  = |(rd_busy & rf.rden);
endmodule

// File: tb/tb_regs_file.sv
// Bench for regs_file: expected outputs are queued per step and compared
// before the next rising edge, with two write ports to exercise collisions.
module tb_regs_file;
    localparam int SEL_RD0   = 0;
    localparam int SEL_RD1   = 1;
    localparam int SEL_BUSY  = 2;
    localparam int SEL_STALL = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_entry_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    sb_entry_t sb_q[$];

    regs_file_if #(.READ_PORTS(2), .WRITE_PORTS(2)) rf_bus ();

    regs_file #(
        .READ_PORTS  (2),
        .WRITE_PORTS (2),
        .REG_NUM     (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int sel, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain;
        sb_entry_t   e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                SEL_RD0:  obs = rf_bus.rddata[0];
                SEL_RD1:  obs = rf_bus.rddata[1];
                SEL_BUSY: obs = {30'd0, rf_bus.busy};
                default:  obs = {31'd0, rf_bus.stall};
            endcase
            check_val(e.tag, obs, e.exp);
        end
    endtask

    task automatic idle;
        rf_bus.we      = '0;
        rf_bus.waddr   = '0;
        rf_bus.wrdata  = '0;
        rf_bus.wlong   = '0;
        rf_bus.sb_set  = 1'b0;
        rf_bus.sb_addr = 5'd0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic en0, input logic [4:0] a1, input logic en1);
        rf_bus.raddr[0] = a0;
        rf_bus.rden[0]  = en0;
        rf_bus.raddr[1] = a1;
        rf_bus.rden[1]  = en1;
    endtask

    task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d, input logic lng);
        rf_bus.we[port]     = 1'b1;
        rf_bus.waddr[port]  = a;
        rf_bus.wrdata[port] = d;
        rf_bus.wlong[port]  = lng;
    endtask

    task automatic settle;
        #2;
        drain();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        rd(5'd5, 1'b1, 5'd0, 1'b1);

        // reset state
        @(negedge clk);
        expect_out("rst_rd0", SEL_RD0, 32'h0);
        expect_out("rst_rd1", SEL_RD1, 32'h0);
        expect_out("rst_busy", SEL_BUSY, 32'h0);
        expect_out("rst_stall", SEL_STALL, 32'h0);
        settle();
        rst_n = 1'b1;

        // write-first bypass, then stored value
        @(negedge clk);
        idle(); rd(5'd3, 1'b1, 5'd0, 1'b0);
        wr(0, 5'd3, 32'hDEADBEEF, 1'b0);
        expect_out("bypass_r3", SEL_RD0, 32'hDEADBEEF);
        settle();
        @(negedge clk);
        idle();
        expect_out("stored_r3", SEL_RD0, 32'hDEADBEEF);
        settle();

        // register 0 ignores writes and scoreboard
        @(negedge clk);
        idle(); rd(5'd0, 1'b1, 5'd0, 1'b1);
        wr(0, 5'd0, 32'h12345678, 1'b0);
        expect_out("r0_bypass", SEL_RD0, 32'h0);
        settle();
        @(negedge clk);
        idle();
        rf_bus.sb_set = 1'b1; rf_bus.sb_addr = 5'd0;
        expect_out("r0_stored", SEL_RD0, 32'h0);
        expect_out("r0_sb_busy_now", SEL_BUSY, 32'h0);
        settle();
        @(negedge clk);
        idle();
        expect_out("r0_sb_busy_next", SEL_BUSY, 32'h0);
        expect_out("r0_sb_stall_next", SEL_STALL, 32'h0);
        settle();

        // long-latency producer on r7
        @(negedge clk);
        idle(); rd(5'd0, 1'b0, 5'd7, 1'b1);
        rf_bus.sb_set = 1'b1; rf_bus.sb_addr = 5'd7;
        expect_out("r7_set_same_cycle_busy", SEL_BUSY, 32'h0);
        settle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            idle();
            expect_out($sformatf("r7_busy_c%0d", k), SEL_BUSY, 32'h2);
            expect_out($sformatf("r7_stall_c%0d", k), SEL_STALL, 32'h1);
            settle();
        end
        @(negedge clk);
        idle();
        wr(0, 5'd7, 32'hCAFEF00D, 1'b1);
        expect_out("r7_wb_busy", SEL_BUSY, 32'h0);
        expect_out("r7_wb_stall", SEL_STALL, 32'h0);
        expect_out("r7_wb_data", SEL_RD1, 32'hCAFEF00D);
        settle();
        @(negedge clk);
        idle();
        rf_bus.sb_set = 1'b1; rf_bus.sb_addr = 5'd7;
        expect_out("r7_cleared_busy", SEL_BUSY, 32'h0);
        expect_out("r7_stored", SEL_RD1, 32'hCAFEF00D);
        settle();
        @(negedge clk);
        idle(); rd(5'd0, 1'b0, 5'd7, 1'b0);
        expect_out("r7_unused_busy", SEL_BUSY, 32'h2);
        expect_out("r7_unused_stall", SEL_STALL, 32'h0);
        settle();

        // set and clear on r9 in the same cycle: set wins
        @(negedge clk);
        idle(); rd(5'd9, 1'b1, 5'd7, 1'b0);
        rf_bus.sb_set = 1'b1; rf_bus.sb_addr = 5'd9;
        settle();
        @(negedge clk);
        idle();
        rf_bus.sb_set = 1'b1; rf_bus.sb_addr = 5'd9;
        wr(0, 5'd9, 32'h00000099, 1'b1);
        expect_out("r9_setclr_busy", SEL_BUSY, 32'h2);
        expect_out("r9_setclr_data", SEL_RD0, 32'h00000099);
        settle();
        @(negedge clk);
        idle();
        expect_out("r9_still_pending", SEL_BUSY, 32'h3);
        expect_out("r9_stall", SEL_STALL, 32'h1);
        expect_out("r9_stored", SEL_RD0, 32'h00000099);
        settle();
        @(negedge clk);
        idle();
        wr(0, 5'd9, 32'h000000AA, 1'b0);
        expect_out("r9_short_wr_busy", SEL_BUSY, 32'h3);
        expect_out("r9_short_wr_data", SEL_RD0, 32'h000000AA);
        settle();
        @(negedge clk);
        idle();
        expect_out("r9_short_after_busy", SEL_BUSY, 32'h3);
        expect_out("r9_short_after_data", SEL_RD0, 32'h000000AA);
        settle();

        // write-port collision: higher port wins
        @(negedge clk);
        idle(); rd(5'd4, 1'b1, 5'd7, 1'b1);
        wr(0, 5'd4, 32'h00000011, 1'b0);
        wr(1, 5'd4, 32'h00000022, 1'b0);
        expect_out("collide_bypass", SEL_RD0, 32'h00000022);
        settle();
        @(negedge clk);
        idle();
        expect_out("collide_stored", SEL_RD0, 32'h00000022);
        expect_out("pre_rst_busy", SEL_BUSY, 32'h2);
        expect_out("pre_rst_stall", SEL_STALL, 32'h1);
        settle();

        // asynchronous reset mid-sequence
        #1;
        rst_n = 1'b0;
        #1;
        expect_out("midrst_busy", SEL_BUSY, 32'h0);
        expect_out("midrst_stall", SEL_STALL, 32'h0);
        expect_out("midrst_rd0", SEL_RD0, 32'h0);
        expect_out("midrst_rd1", SEL_RD1, 32'h0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        idle(); rd(5'd5, 1'b1, 5'd9, 1'b1);
        wr(0, 5'd5, 32'h00000055, 1'b0);
        settle();
        @(negedge clk);
        idle();
        expect_out("post_rst_write", SEL_RD0, 32'h00000055);
        expect_out("post_rst_r9_busy", SEL_BUSY, 32'h0);
        expect_out("post_rst_r9_data", SEL_RD1, 32'h0);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
